// File: rtl/trivium_pkg.sv
// Shared types and constants for the Trivium cipher datapath blocks.
package trivium_pkg;

  typedef enum logic [1:0] {
    FC_EMPTY = 2'b00,
    FC_PART  = 2'b01,
    FC_FULL  = 2'b10,
    FC_OVF   = 2'b11
  } fifo_cnd_t;

  // Bit positions inside the core status register sign_reg.
  localparam int SIGN_MOVING    = 0;
  localparam int SIGN_READY     = 1;
  localparam int SIGN_ERROR     = 2;
  localparam int SIGN_TOTAL_RST = 3;

endpackage

// File: rtl/cipher_fifo_mem.sv
// DEPTH x 8 byte storage: one synchronous write port, one combinational read port, no reset.
module cipher_fifo_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cipher_out_fifo.sv
// Output byte FIFO for the Trivium core: memory FIFO feeding a registered valid/ready stage,
// with fifo_cnd status fed back to the core so it can pause between bursts.
module cipher_out_fifo
  import trivium_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    stream,
  input  logic          wt_sgn,
  input  logic [7:0]    sign_reg,
  input  logic          clr,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    fifo_cnd,
  output logic [AW+1:0] level,
  output logic          ovf
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   mem_count_q, mem_count_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          ovf_q, ovf_d;

  logic       flush, load, push_acc, mem_we;
  logic [7:0] mem_rdata;
  logic       unused_sign;
  fifo_cnd_t  cnd;

  assign flush       = clr | sign_reg[SIGN_TOTAL_RST];
  assign unused_sign = ^{sign_reg[7:4], sign_reg[2:0]};

  // A full memory can still take a byte when the output stage pops one on the same edge.
  assign load     = (!out_valid_q | out_ready) & (mem_count_q != '0);
  assign push_acc = wt_sgn & ((mem_count_q != FULL_COUNT) | load);
  assign mem_we   = push_acc & !flush;

  cipher_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (stream),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      else if (wt_sgn) ovf_d = 1'b1;
      if (load) begin
        rd_ptr_d    = rd_ptr_q + AW'(1);
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
      end else if (out_valid_q & out_ready) begin
        out_valid_d = 1'b0;
      end
      case ({push_acc, load})
        2'b10:   mem_count_d = mem_count_q + (AW+1)'(1);
        2'b01:   mem_count_d = mem_count_q - (AW+1)'(1);
        default: mem_count_d = mem_count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign level = (AW+2)'(mem_count_q) + (AW+2)'(out_valid_q);

  always_comb begin
    if (ovf_q)                          cnd = FC_OVF;
    else if (mem_count_q == FULL_COUNT) cnd = FC_FULL;
    else if (level == '0)               cnd = FC_EMPTY;
    else                                cnd = FC_PART;
  end

  assign fifo_cnd  = cnd;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cipher_out_fifo.sv
// Randomized and directed bench for cipher_out_fifo, checked against a queue-based reference model.
module tb_cipher_out_fifo;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);

  logic          clk, rst;
  logic [7:0]    stream, sign_reg;
  logic          wt_sgn, clr, out_ready;
  logic [7:0]    out_data;
  logic          out_valid, ovf;
  logic [1:0]    fifo_cnd;
  logic [AW+1:0] level;

  int total = 0;
  int bad   = 0;

  // Reference model: stored bytes as a plain queue plus the output holding register.
  logic [7:0] mq[$];
  logic       mv;
  logic [7:0] md;
  logic       movf;
  int         max_level;

  cipher_out_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .stream    (stream),
    .wt_sgn    (wt_sgn),
    .sign_reg  (sign_reg),
    .clr       (clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_cnd  (fifo_cnd),
    .level     (level),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mv   = 1'b0;
    md   = 8'h00;
    movf = 1'b0;
  endtask

  function automatic int expLevel();
    return mq.size() + int'(mv);
  endfunction

  function automatic logic [1:0] expCnd();
    if (movf) return 2'b11;
    if (mq.size() == DEPTH) return 2'b10;
    if (expLevel() == 0) return 2'b00;
    return 2'b01;
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'(mv));
    checkOutput({tag, "_data"},  32'(out_data),  32'(md));
    checkOutput({tag, "_level"}, 32'(level),     32'(expLevel()));
    checkOutput({tag, "_cnd"},   32'(fifo_cnd),  32'(expCnd()));
    checkOutput({tag, "_ovf"},   32'(ovf),       32'(movf));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic applyStimulus(input string tag, input logic w, input logic [7:0] d,
                               input logic rdy, input logic c, input logic [7:0] sr);
    bit ld, acc;
    wt_sgn = w; stream = d; out_ready = rdy; clr = c; sign_reg = sr;
    @(posedge clk);
    if (!rst) modelReset();
    else if (c || sr[3]) begin
      mq.delete();
      mv   = 1'b0;
      movf = 1'b0;
    end else begin
      ld  = (!mv || rdy) && mq.size() != 0;
      acc = w && (mq.size() < DEPTH || ld);
      if (ld) begin
        md = mq.pop_front();
        mv = 1'b1;
      end else if (mv && rdy) mv = 1'b0;
      if (acc) mq.push_back(d);
      else if (w) movf = 1'b1;
    end
    #1;
    if (int'(level) > max_level) max_level = int'(level);
    compareAll(tag);
  endtask

  initial begin
    rst = 1'b0; wt_sgn = 1'b0; stream = 8'h00; sign_reg = 8'h00; clr = 1'b0; out_ready = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compareAll("rst");
    rst = 1'b1;

    // 1: three bytes held back, then drained at full rate
    applyStimulus("t1", 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00);
    applyStimulus("t1", 1'b1, 8'hA2, 1'b0, 1'b0, 8'h00);
    applyStimulus("t1", 1'b1, 8'hA3, 1'b0, 1'b0, 8'h00);
    checkOutput("t1_level3", 32'(level), 32'd3);
    checkOutput("t1_head", 32'(out_data), 32'hA1);
    checkOutput("t1_cnd01", 32'(fifo_cnd), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus("t1d", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    checkOutput("t1_empty", 32'(fifo_cnd), 32'd0);

    // 2: overfill, then drain; the overflow status must stick until a flush
    for (int i = 0; i < 257; i++) applyStimulus("t2f", 1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
    checkOutput("t2_full_cnd", 32'(fifo_cnd), 32'd2);
    applyStimulus("t2o", 1'b1, 8'hEE, 1'b0, 1'b0, 8'h00);
    checkOutput("t2_ovf", 32'(ovf), 32'd1);
    for (int i = 0; i < 260; i++) applyStimulus("t2d", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    checkOutput("t2_sticky_cnd", 32'(fifo_cnd), 32'd3);
    applyStimulus("t2c", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    checkOutput("t2_clr_cnd", 32'(fifo_cnd), 32'd0);

    // 3: streaming through two pointer wraps
    max_level = 0;
    for (int i = 0; i < 600; i++) applyStimulus("t3", 1'b1, 8'(i), 1'b1, 1'b0, 8'h00);
    checkOutput("t3_lvl_le2", 32'(max_level <= 2), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus("t3d", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // 4: Total_RST flush while pushing
    for (int i = 0; i < 10; i++) applyStimulus("t4f", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00);
    applyStimulus("t4x", 1'b1, 8'h99, 1'b0, 1'b0, 8'h08);
    checkOutput("t4_level0", 32'(level), 32'd0);
    checkOutput("t4_valid0", 32'(out_valid), 32'd0);
    applyStimulus("t4i", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // 5: push into a full memory while the head drains
    for (int i = 0; i < 257; i++) applyStimulus("t5f", 1'b1, 8'(i ^ 8'h5A), 1'b0, 1'b0, 8'h00);
    applyStimulus("t5x", 1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
    checkOutput("t5_level", 32'(level), 32'd257);
    checkOutput("t5_ovf0", 32'(ovf), 32'd0);
    applyStimulus("t5c", 1'b0, 8'h00, 1'b0, 1'b1, 8'h00);

    // 6: asynchronous reset mid-drain
    for (int i = 0; i < 4; i++) applyStimulus("t6f", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 8'h00);
    applyStimulus("t6d", 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_async_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_async_level", 32'(level), 32'd0);
    checkOutput("t6_async_cnd", 32'(fifo_cnd), 32'd0);
    modelReset();
    applyStimulus("t6r", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    rst = 1'b1;
    applyStimulus("t6p", 1'b1, 8'h5C, 1'b0, 1'b0, 8'h00);
    applyStimulus("t6w", 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    checkOutput("t6_5c", 32'(out_data), 32'h5C);
    checkOutput("t6_5c_valid", 32'(out_valid), 32'd1);

    // Random traffic with occasional flushes from either source
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] sr;
      sr = 8'($urandom) & 8'hF7;
      if ($urandom_range(0, 99) == 0) sr[3] = 1'b1;
      applyStimulus("rnd", $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 199) == 0, sr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
